// File: rtl/pll_sup_pkg.sv
// Shared definitions for the PLL lock supervisor: state encoding, counter
// widths and a small constant helper used to size the shared cycle counter.
package pll_sup_pkg;

    // Supervisor states, in bring-up order.
    typedef enum logic [2:0] {
        PLL_RST   = 3'd0,
        WAIT_LOCK = 3'd1,
        STABLE    = 3'd2,
        RUN       = 3'd3,
        FAIL      = 3'd4
    } pll_sup_state_t;

    // Width of the reported retry count (saturates at all-ones).
    localparam int RETRY_W = 4;

    // Width of the optional lock-loss counter (saturates at all-ones).
    localparam int LOSS_W = 8;

    // Largest of three cycle counts; sizes the single shared cycle counter.
    function automatic int max3(input int a, input int b, input int c);
        int m;
        m = a;
        if (b > m) m = b;
        if (c > m) m = c;
        return m;
    endfunction

endpackage

// File: rtl/pll_sup_sync.sv
// N-stage single-bit synchronizer with synchronous reset to 0.
// Intended for slow asynchronous status flags (PLL locked and similar);
// STAGES must be at least 2.
module pll_sup_sync #(
    parameter int STAGES = 2
) (
    input  logic clk,
    input  logic rst,
    input  logic d,
    output logic q
);

    logic [STAGES-1:0] sync_q;

    // Shift the asynchronous input through the flop chain; bit 0 is the
    // only flop that may go metastable.
    always_ff @(posedge clk) begin
        if (rst) begin
            sync_q <= '0;
        end else begin
            sync_q <= {sync_q[STAGES-2:0], d};
        end
    end

    assign q = sync_q[STAGES-1];

endmodule

// File: rtl/pll_lock_supervisor.sv
// PLL lock supervisor: pulses the PLL reset, waits for a synchronized lock,
// requires lock to stay up for a stability window before releasing the
// system reset, and restarts the sequence on lock loss. Lock timeouts are
// retried a bounded number of times before a sticky fatal failure.
//
// Optional build macro: PLL_SUP_LOSS_CNT_EN adds lock_loss_cnt_o, a
// saturating count of RUN -> PLL_RST transitions cleared only by rst.
//
// All outputs are registered and decoded from the next state, so they
// change on the same edge as the state register.
module pll_lock_supervisor
    import pll_sup_pkg::*;
#(
    parameter int SYNC_STAGES         = 2,
    parameter int RST_PULSE_CYCLES    = 16,
    parameter int LOCK_TIMEOUT_CYCLES = 50000,
    parameter int STABLE_CYCLES       = 1024,
    parameter int MAX_RETRIES         = 3
) (
    input  logic               refclk,
    input  logic               rst,
    input  logic               pll_locked_i,
    output logic               pll_rst_o,
    output logic               sys_rst_o,
    output logic               ready_o,
    output logic               fail_o,
    output logic [RETRY_W-1:0] retry_cnt_o
`ifdef PLL_SUP_LOSS_CNT_EN
    ,
    output logic [LOSS_W-1:0]  lock_loss_cnt_o
`endif
);

    // Shared cycle counter sized for the longest of the three windows.
    localparam int CNT_MAX = max3(RST_PULSE_CYCLES, LOCK_TIMEOUT_CYCLES, STABLE_CYCLES);
    localparam int CNT_W   = $clog2(CNT_MAX) + 1;

    localparam logic [CNT_W-1:0] RST_LAST     = CNT_W'(RST_PULSE_CYCLES - 1);
    localparam logic [CNT_W-1:0] TIMEOUT_LAST = CNT_W'(LOCK_TIMEOUT_CYCLES - 1);
    localparam logic [CNT_W-1:0] STABLE_LAST  = CNT_W'(STABLE_CYCLES - 1);

    // Exact timeout tally used for the FAIL decision. It is kept apart from
    // retry_cnt_o because that output saturates at 15 and would otherwise
    // hide timeouts once MAX_RETRIES is large.
    localparam int                TMO_W     = $clog2(MAX_RETRIES + 2);
    localparam logic [TMO_W-1:0]  TMO_LIMIT = TMO_W'(MAX_RETRIES);

    localparam logic [RETRY_W-1:0] RETRY_MAX = '1;

    // Synchronized lock flag; every decision below uses this, never the pin.
    logic lk;

    // FSM state (also useful as a debug probe) and the shared counter.
    pll_sup_state_t    state;
    pll_sup_state_t    next_state;
    logic [CNT_W-1:0]  cnt;
    logic [TMO_W-1:0]  tmo_cnt;

    // Decisions taken this cycle.
    logic timeout_hit;
    logic retry_clr;
    logic timed_state;

    pll_sup_sync #(
        .STAGES (SYNC_STAGES)
    ) u_lock_sync (
        .clk (refclk),
        .rst (rst),
        .d   (pll_locked_i),
        .q   (lk)
    );

    // Counter only advances in the states that time something.
    assign timed_state = (state == PLL_RST) || (state == WAIT_LOCK) || (state == STABLE);

    // Next-state decode. Priorities: lock arriving beats a coinciding
    // timeout, and lock dropping beats a coinciding end of the stable window.
    always_comb begin
        next_state  = state;
        timeout_hit = 1'b0;
        retry_clr   = 1'b0;
        case (state)
            PLL_RST: begin
                if (cnt == RST_LAST) begin
                    next_state = WAIT_LOCK;
                end
            end
            WAIT_LOCK: begin
                if (lk) begin
                    next_state = STABLE;
                end else if (cnt == TIMEOUT_LAST) begin
                    timeout_hit = 1'b1;
                    // This timeout pushes the tally past the allowance when
                    // the earlier ones already used it all up.
                    if (tmo_cnt == TMO_LIMIT) begin
                        next_state = FAIL;
                    end else begin
                        next_state = PLL_RST;
                    end
                end
            end
            STABLE: begin
                if (!lk) begin
                    // Lock bounced: restart the lock timeout without
                    // counting a retry; the window restarts on re-entry.
                    next_state = WAIT_LOCK;
                end else if (cnt == STABLE_LAST) begin
                    next_state = RUN;
                    retry_clr  = 1'b1;
                end
            end
            RUN: begin
                if (!lk) begin
                    next_state = PLL_RST;
                end
            end
            FAIL: begin
                next_state = FAIL;
            end
            default: begin
                next_state = PLL_RST;
            end
        endcase
    end

    // State register, shared counter, retry bookkeeping and registered
    // outputs decoded from the next state.
    always_ff @(posedge refclk) begin
        if (rst) begin
            state       <= PLL_RST;
            cnt         <= '0;
            tmo_cnt     <= '0;
            retry_cnt_o <= '0;
            pll_rst_o   <= 1'b1;
            sys_rst_o   <= 1'b1;
            ready_o     <= 1'b0;
            fail_o      <= 1'b0;
        end else begin
            state <= next_state;

            if (next_state != state) begin
                cnt <= '0;
            end else if (timed_state) begin
                cnt <= cnt + CNT_W'(1);
            end

            if (retry_clr) begin
                retry_cnt_o <= '0;
                tmo_cnt     <= '0;
            end else if (timeout_hit) begin
                if (retry_cnt_o != RETRY_MAX) begin
                    retry_cnt_o <= retry_cnt_o + RETRY_W'(1);
                end
                tmo_cnt <= tmo_cnt + TMO_W'(1);
            end

            pll_rst_o <= (next_state == PLL_RST) || (next_state == FAIL);
            sys_rst_o <= (next_state != RUN);
            ready_o   <= (next_state == RUN);
            fail_o    <= (next_state == FAIL);
        end
    end

`ifdef PLL_SUP_LOSS_CNT_EN
    // Count lock losses seen while running, saturating at all-ones.
    always_ff @(posedge refclk) begin
        if (rst) begin
            lock_loss_cnt_o <= '0;
        end else if ((state == RUN) && (next_state == PLL_RST) &&
                     (lock_loss_cnt_o != {LOSS_W{1'b1}})) begin
            lock_loss_cnt_o <= lock_loss_cnt_o + LOSS_W'(1);
        end
    end
`endif

endmodule
